puf_eval_ctrl: RTL and testbench
================================

Name: puf_eval_ctrl

Overview:
- Sequencer for the 16-instance PDL arbiter PUF array (128-bit challenge, shared trigger/reset, 16-bit response).
- Latches a host challenge, applies it, and runs NUM_EVAL reset/settle/trigger/sample cycles.
- Majority-votes each response bit and reports a per-bit stability mask.
- Sits between the host/Ethernet command logic and the PUF array; it is the only driver of the array's challenge, trigger and reset.

Parameters:
- RST_CYCLES, 4: cycles puf_reset is held high before each evaluation (1..255).
- SETTLE_CYCLES, 8: cycles with the challenge applied and trigger low before firing (1..255).
- FIRE_CYCLES, 16: cycles trigger is held high; the arbiters resolve during this window (3..255).
- NUM_EVAL, 15: evaluations per challenge. Must be odd, 1..255.
- CNT_W, $clog2(NUM_EVAL+1): per-bit ones-counter width (derived).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: request evaluation of challenge_in. Sampled only in IDLE.
- challenge_in, in, 128: challenge. [63:0] goes to the top delay line, [127:64] to the bottom delay line.
- abort, in, 1: cancel the evaluation in progress.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when response_out and stable_out are valid.
- response_out, out, 16: majority-voted response.
- stable_out, out, 16: bit i is 1 when all NUM_EVAL samples of bit i agreed.
- puf_challenge, out, 128: challenge bus to the PUF array.
- puf_trigger, out, 1: shared arbiter trigger.
- puf_reset, out, 1: shared PUF reset, active-high.
- puf_response, in, 16: raw arbiter outputs. Asynchronous to clk.

Behaviour:
- Reset (reset=0) values:
  - state=IDLE.
  - busy=0, done=0.
  - response_out=0, stable_out=0.
  - puf_challenge=0, puf_trigger=0, puf_reset=1.
  - eval counter, phase counter, ones counters and synchronizer all 0.
- puf_response passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- States and transitions:
  - IDLE: puf_reset=1, puf_trigger=0.
    - start=1 → latch challenge_in into puf_challenge, clear ones counters and eval counter, go to PRST.
    - start while busy is ignored; no queueing.
  - PRST: puf_reset=1 for RST_CYCLES cycles, then go to SETTLE.
  - SETTLE: puf_reset=0, puf_trigger=0 for SETTLE_CYCLES cycles, then go to FIRE.
  - FIRE: puf_trigger=1 for FIRE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE (1 cycle): puf_trigger=0. For each bit i, add the synchronized bit to ones[i]; increment the eval counter.
    - If the eval counter reaches NUM_EVAL → VOTE; otherwise → PRST.
  - VOTE (1 cycle):
    - response_out[i] = (ones[i] >= (NUM_EVAL+1)/2).
    - stable_out[i] = (ones[i]==0) or (ones[i]==NUM_EVAL).
    - Go to DONE.
  - DONE (1 cycle): done=1, then go to IDLE.
- Latency:
  - One evaluation = RST_CYCLES + SETTLE_CYCLES + FIRE_CYCLES + 1 cycles.
  - done is high in cycle NUM_EVAL*(R+S+F+1)+2 after the clock edge that accepts start.
  - With defaults: 15*29+2 = 437.
- Per-evaluation timing rules:
  - puf_trigger never rises in the same cycle puf_reset falls.
  - puf_trigger is low for at least one cycle between evaluations.
- puf_challenge holds the latched value from acceptance until the next accepted start. It is not changed by done or abort.
- response_out and stable_out change only in VOTE and hold until the next VOTE.
- abort:
  - Effective in any busy state: next cycle is IDLE with puf_trigger=0, puf_reset=1.
  - No done pulse; response_out and stable_out are unchanged.
  - Simultaneous abort and start in IDLE: start wins; abort is ignored while in IDLE.
- Ones counters never overflow, since CNT_W covers NUM_EVAL.
- reset asserted mid-evaluation: immediate return to the reset values; no done pulse.

Decomposition:
- Shared package puf_ctrl_pkg holds:
  - State enum: IDLE, PRST, SETTLE, FIRE, SAMPLE, VOTE, DONE.
  - PUF_CHAL_W=128, PUF_RESP_W=16.
- One natural sub-module, puf_vote_acc: 16 ones counters, clear/accumulate inputs, majority and stability outputs. Instantiated once.

Test Plan:
- Defaults; puf_response tied to 16'hA5C3; start with challenge 128'h0123..CDEF → done exactly 437 cycles after start; response_out=16'hA5C3, stable_out=16'hFFFF; puf_challenge equals the input.
- Model returns 16'h00FF for 8 evals and 16'hFF00 for 7, ordered per eval → response_out=16'h00FF, stable_out=16'h0000.
- Bit 0 is 1 in exactly 8 of 15 evals, all others 0 → response_out=16'h0001, stable_out=16'hFFFE (boundary of the >=8 threshold).
- Check every evaluation: puf_trigger low on the cycle puf_reset falls; trigger high for exactly 16 cycles, low ≥1 cycle between; 15 trigger pulses per start.
- abort at cycle 100 → busy low at 101, no done pulse, previous response_out/stable_out retained; new start afterwards completes normally in 437 cycles.
- start pulsed while busy → ignored (single done pulse only). reset low mid-FIRE → all outputs at their reset values; next start is accepted.

Source files
------------

// File: rtl/puf_ctrl_pkg.sv
// Shared types and widths for the arbiter PUF evaluation sequencer.
package puf_ctrl_pkg;

  localparam int PUF_CHAL_W = 128;
  localparam int PUF_RESP_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRST,
    SETTLE,
    FIRE,
    SAMPLE,
    VOTE,
    DONE
  } state_t;

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit ones counters for repeated PUF evaluations, with majority and
// all-samples-agree outputs derived from the counts.
module puf_vote_acc
  import puf_ctrl_pkg::*;
#(
  parameter int NUM_EVAL = 15,
  parameter int CNT_W    = $clog2(NUM_EVAL + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  acc,
  input  logic [PUF_RESP_W-1:0] sample_bits,
  output logic [PUF_RESP_W-1:0] majority,
  output logic [PUF_RESP_W-1:0] stable
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'((NUM_EVAL + 1) / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_EVAL);

  logic [CNT_W-1:0] ones [PUF_RESP_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PUF_RESP_W; i++) ones[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < PUF_RESP_W; i++) ones[i] <= '0;
    end else if (acc) begin
      for (int i = 0; i < PUF_RESP_W; i++) ones[i] <= ones[i] + CNT_W'(sample_bits[i]);
    end
  end

  always_comb begin
    majority = '0;
    stable   = '0;
    for (int i = 0; i < PUF_RESP_W; i++) begin
      majority[i] = (ones[i] >= HALF);
      stable[i]   = (ones[i] == '0) || (ones[i] == FULL);
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer driving the PUF array through repeated reset/settle/fire/sample
// evaluations of one latched challenge, then majority-voting the response.
module puf_eval_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int FIRE_CYCLES   = 16,
  parameter int NUM_EVAL      = 15,
  parameter int CNT_W         = $clog2(NUM_EVAL + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PUF_CHAL_W-1:0] challenge_in,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [PUF_RESP_W-1:0] response_out,
  output logic [PUF_RESP_W-1:0] stable_out,
  output logic [PUF_CHAL_W-1:0] puf_challenge,
  output logic                  puf_trigger,
  output logic                  puf_reset,
  input  logic [PUF_RESP_W-1:0] puf_response
);

  localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] FIRE_LAST   = 8'(FIRE_CYCLES - 1);
  localparam logic [7:0] EVAL_LAST   = 8'(NUM_EVAL - 1);

  state_t                state;
  logic [7:0]            phase;
  logic [7:0]            eval_cnt;
  logic [PUF_RESP_W-1:0] resp_meta;
  logic [PUF_RESP_W-1:0] resp_sync;
  logic [PUF_RESP_W-1:0] majority;
  logic [PUF_RESP_W-1:0] stable;
  logic                  acc_clr;
  logic                  acc_en;

  // Arbiter outputs settle asynchronously to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_meta <= '0;
      resp_sync <= '0;
    end else begin
      resp_meta <= puf_response;
      resp_sync <= resp_meta;
    end
  end

  assign acc_clr = (state == IDLE) && start;
  assign acc_en  = (state == SAMPLE) && !abort;

  puf_vote_acc #(
    .NUM_EVAL (NUM_EVAL),
    .CNT_W    (CNT_W)
  ) u_vote_acc (
    .clk         (clk),
    .reset       (reset),
    .clr         (acc_clr),
    .acc         (acc_en),
    .sample_bits (resp_sync),
    .majority    (majority),
    .stable      (stable)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      phase         <= '0;
      eval_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      response_out  <= '0;
      stable_out    <= '0;
      puf_challenge <= '0;
      puf_trigger   <= 1'b0;
      puf_reset     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          puf_challenge <= challenge_in;
          eval_cnt      <= '0;
          phase         <= '0;
          busy          <= 1'b1;
          puf_reset     <= 1'b1;
          state         <= PRST;
        end
      end else if (abort) begin
        state       <= IDLE;
        phase       <= '0;
        busy        <= 1'b0;
        puf_trigger <= 1'b0;
        puf_reset   <= 1'b1;
      end else begin
        case (state)
          PRST: begin
            if (phase == RST_LAST) begin
              phase     <= '0;
              puf_reset <= 1'b0;
              state     <= SETTLE;
            end else phase <= phase + 8'd1;
          end
          SETTLE: begin
            // Trigger rises only after at least one cycle out of reset.
            if (phase == SETTLE_LAST) begin
              phase       <= '0;
              puf_trigger <= 1'b1;
              state       <= FIRE;
            end else phase <= phase + 8'd1;
          end
          FIRE: begin
            if (phase == FIRE_LAST) begin
              phase       <= '0;
              puf_trigger <= 1'b0;
              state       <= SAMPLE;
            end else phase <= phase + 8'd1;
          end
          SAMPLE: begin
            eval_cnt <= eval_cnt + 8'd1;
            if (eval_cnt == EVAL_LAST) begin
              state <= VOTE;
            end else begin
              puf_reset <= 1'b1;
              state     <= PRST;
            end
          end
          VOTE: begin
            response_out <= majority;
            stable_out   <= stable;
            done         <= 1'b1;
            state        <= DONE;
          end
          default: begin
            busy      <= 1'b0;
            puf_reset <= 1'b1;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Randomized bench for puf_eval_ctrl against a timeline/vote model of the sequencer.
module tb_puf_eval_ctrl;

  localparam int R        = 4;
  localparam int S        = 8;
  localparam int F        = 16;
  localparam int NEVAL    = 15;
  localparam int EVAL_LEN = R + S + F + 1;
  localparam int T_VOTE   = NEVAL * EVAL_LEN;
  localparam int T_DONE   = T_VOTE + 1;
  localparam int LATENCY  = T_DONE + 1;

  logic         clk          = 1'b0;
  logic         reset        = 1'b1;
  logic         start        = 1'b0;
  logic         abort        = 1'b0;
  logic [127:0] challenge_in = '0;
  logic [15:0]  puf_response = '0;
  logic         busy;
  logic         done;
  logic [15:0]  response_out;
  logic [15:0]  stable_out;
  logic [127:0] puf_challenge;
  logic         puf_trigger;
  logic         puf_reset;

  puf_eval_ctrl #(
    .RST_CYCLES    (R),
    .SETTLE_CYCLES (S),
    .FIRE_CYCLES   (F),
    .NUM_EVAL      (NEVAL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .challenge_in  (challenge_in),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .response_out  (response_out),
    .stable_out    (stable_out),
    .puf_challenge (puf_challenge),
    .puf_trigger   (puf_trigger),
    .puf_reset     (puf_reset),
    .puf_response  (puf_response)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  pat [NEVAL];
  bit           garbage = 1'b0;
  int           t = -1;
  logic [15:0]  m_resp = '0;
  logic [15:0]  m_stab = '0;
  logic [127:0] m_chal = '0;
  int           done_cnt = 0;
  int           trig_pulses = 0;
  logic         prev_trig = 1'b0;
  logic         e_busy, e_done, e_trig, e_rst;
  int           ph, ev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_vote(output logic [15:0] r, output logic [15:0] s);
    for (int i = 0; i < 16; i++) begin
      int c;
      c = 0;
      for (int k = 0; k < NEVAL; k++) c += int'(pat[k][i]);
      r[i] = (c >= (NEVAL + 1) / 2);
      s[i] = (c == 0) || (c == NEVAL);
    end
  endfunction

  // Model: t counts cycles since the accepting edge, -1 when idle.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      t = -1; m_resp = '0; m_stab = '0; m_chal = '0;
    end else if (t < 0) begin
      if (start) begin
        t = 0;
        m_chal = challenge_in;
      end
    end else if (abort || t == T_DONE) begin
      t = -1;
    end else begin
      t++;
      if (t == T_DONE) model_vote(m_resp, m_stab);
    end
  end

  // Per-cycle compare, then drive the arbiter outputs for the current evaluation.
  initial forever begin
    @(negedge clk);
    if (t < 0) begin
      e_busy = 1'b0; e_done = 1'b0; e_trig = 1'b0; e_rst = 1'b1;
    end else if (t < T_VOTE) begin
      ph = t % EVAL_LEN;
      e_busy = 1'b1; e_done = 1'b0;
      e_rst  = (ph < R);
      e_trig = (ph >= R + S) && (ph < R + S + F);
    end else begin
      e_busy = 1'b1; e_done = (t == T_DONE); e_trig = 1'b0; e_rst = 1'b0;
    end
    check("busy",          128'(busy),        128'(e_busy));
    check("done",          128'(done),        128'(e_done));
    check("puf_trigger",   128'(puf_trigger), 128'(e_trig));
    check("puf_reset",     128'(puf_reset),   128'(e_rst));
    check("response_out",  128'(response_out), 128'(m_resp));
    check("stable_out",    128'(stable_out),  128'(m_stab));
    check("puf_challenge", puf_challenge,     m_chal);
    if (done) done_cnt++;
    if (puf_trigger && !prev_trig) trig_pulses++;
    prev_trig = puf_trigger;
    if (t >= 0 && t < T_VOTE) begin
      ev = t / EVAL_LEN;
      ph = t % EVAL_LEN;
      puf_response = (garbage && ph < R + S) ? ~pat[ev] : pat[ev];
    end
  end

  task automatic accept(input logic [127:0] ch, input bit with_abort);
    @(posedge clk); #1;
    challenge_in = ch; start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic run(input logic [127:0] ch, input bit with_abort, input int busy_start_at,
                     output int lat);
    int p0, d0;
    accept(ch, with_abort);
    p0 = trig_pulses;
    d0 = done_cnt;
    for (lat = 1; lat < 1000; lat++) begin
      @(negedge clk);
      start = (lat == busy_start_at);
      if (lat == busy_start_at) challenge_in = ~ch;
      if (done) break;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("trigger_pulses", 128'(trig_pulses - p0), 128'(NEVAL));
    check("done_pulses",    128'(done_cnt - d0),    128'(1));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int lat, d0;
    logic [15:0] base, mask;
    logic [127:0] ch;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",      128'(busy),         128'(0));
    check("rst_puf_reset", 128'(puf_reset),    128'(1));
    check("rst_response",  128'(response_out), 128'(0));
    @(posedge clk); #1 reset = 1'b1;

    // Constant response
    for (int k = 0; k < NEVAL; k++) pat[k] = 16'hA5C3;
    garbage = 1'b0;
    ch = 128'h0123456789ABCDEF0123456789ABCDEF;
    run(ch, 1'b0, 0, lat);
    check("lat_const",   128'(lat),          128'(LATENCY));
    check("resp_const",  128'(response_out), 128'(16'hA5C3));
    check("stab_const",  128'(stable_out),   128'(16'hFFFF));
    check("chal_const",  puf_challenge,      ch);

    // 8 x 00FF then 7 x FF00
    for (int k = 0; k < NEVAL; k++) pat[k] = (k < 8) ? 16'h00FF : 16'hFF00;
    garbage = 1'b1;
    run(rand128(), 1'b0, 0, lat);
    check("lat_split",  128'(lat),          128'(LATENCY));
    check("resp_split", 128'(response_out), 128'(16'h00FF));
    check("stab_split", 128'(stable_out),   128'(16'h0000));

    // Bit 0 set in exactly 8 evaluations; start pulsed while busy
    for (int k = 0; k < NEVAL; k++) pat[k] = (k < 8) ? 16'h0001 : 16'h0000;
    run(rand128(), 1'b0, 50, lat);
    check("lat_thresh",  128'(lat),          128'(LATENCY));
    check("resp_thresh", 128'(response_out), 128'(16'h0001));
    check("stab_thresh", 128'(stable_out),   128'(16'hFFFE));

    // Abort at cycle 100
    for (int k = 0; k < NEVAL; k++) pat[k] = 16'($urandom);
    accept(rand128(), 1'b0);
    d0 = done_cnt;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 100) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",      128'(busy),         128'(0));
    check("abort_trigger",   128'(puf_trigger),  128'(0));
    check("abort_puf_reset", 128'(puf_reset),    128'(1));
    check("abort_resp",      128'(response_out), 128'(16'h0001));
    check("abort_stab",      128'(stable_out),   128'(16'hFFFE));
    repeat (5) @(negedge clk);
    check("abort_no_done",   128'(done_cnt - d0), 128'(0));
    run(rand128(), 1'b0, 0, lat);
    check("lat_after_abort", 128'(lat), 128'(LATENCY));

    // Reset asserted mid-FIRE of the first evaluation
    for (int k = 0; k < NEVAL; k++) pat[k] = 16'($urandom);
    accept(rand128(), 1'b0);
    for (int c = 1; c <= 20; c++) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy",      128'(busy),         128'(0));
    check("midrst_trigger",   128'(puf_trigger),  128'(0));
    check("midrst_puf_reset", 128'(puf_reset),    128'(1));
    check("midrst_resp",      128'(response_out), 128'(0));
    check("midrst_stab",      128'(stable_out),   128'(0));
    check("midrst_chal",      puf_challenge,      128'(0));
    @(posedge clk); #1 reset = 1'b1;
    run(rand128(), 1'b0, 0, lat);
    check("lat_after_reset", 128'(lat), 128'(LATENCY));

    // Random partially-stable responses; first run has abort alongside start in IDLE
    for (int r = 0; r < 6; r++) begin
      base = 16'($urandom);
      mask = 16'($urandom);
      for (int k = 0; k < NEVAL; k++) pat[k] = base ^ (16'($urandom) & mask);
      run(rand128(), (r == 0), (r == 3) ? 200 : 0, lat);
      check("lat_random", 128'(lat), 128'(LATENCY));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
